adder_arb: RTL and testbench

ADDER_ARB -- requirements
Module: adder_arb

---
 rtl/adder_pkg.sv | 12 +
 rtl/adder_reg.sv | 29 ++
 rtl/adder_arb.sv | 98 +++++++++
 tb/tb_adder_arb.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared definitions for the round-robin adder arbiter: FSM encoding and default sizes.
package adder_pkg;

  localparam int DEF_BITWIDTH = 32;
  localparam int DEF_NREQ     = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_e;

endpackage

// File: rtl/adder_reg.sv
// Registered adder with enable and synchronous clear; result is one bit wider to keep the carry.
module adder_reg #(
  parameter int BITWIDTH = 32
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_en,
  input  logic                i_clr,
  input  logic [BITWIDTH-1:0] i_a,
  input  logic [BITWIDTH-1:0] i_b,
  output logic [BITWIDTH:0]   o_sum
);

  logic [BITWIDTH:0] r_sum;

  // Clear wins over enable so an abort always leaves a zero result.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sum <= '0;
    end else if (i_clr) begin
      r_sum <= '0;
    end else if (i_en) begin
      r_sum <= {1'b0, i_a} + {1'b0, i_b};
    end
  end

  assign o_sum = r_sum;

endmodule

// File: rtl/adder_arb.sv
// Shares one registered adder among NREQ requesters using a round-robin grant,
// holding each result until the consumer accepts it.
module adder_arb
  import adder_pkg::*;
#(
  parameter  int BITWIDTH = DEF_BITWIDTH,
  parameter  int NREQ     = DEF_NREQ,
  localparam int IDW      = $clog2(NREQ)
) (
  input  logic                           iClk,
  input  logic                           iRstN,
  input  logic [NREQ-1:0]                iReqValid,
  output logic [NREQ-1:0]                oReqReady,
  input  logic [NREQ-1:0][BITWIDTH-1:0]  iReqData0,
  input  logic [NREQ-1:0][BITWIDTH-1:0]  iReqData1,
  output logic                           oRspValid,
  input  logic                           iRspReady,
  output logic [IDW-1:0]                 oRspId,
  output logic [BITWIDTH:0]              oRspData,
  input  logic                           iFlush,
  output logic                           oBusy,
  output state_e                         oDbgState
);

  // Handshakes: a request transfers on an edge where iReqValid[g] & oReqReady[g];
  // a response transfers on an edge where oRspValid & iRspReady. iFlush overrides both.

  state_e           r_state;
  logic [IDW-1:0]   r_rr_ptr;
  logic [IDW-1:0]   r_rsp_id;
  logic [IDW:0]     w_pick;
  logic             w_grant;
  logic [IDW-1:0]   w_gid;
  logic [BITWIDTH:0] w_sum;

  // Returns {found, index} of the first valid bit at or above ptr, wrapping to 0.
  function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] valid,
                                           input logic [IDW-1:0]  ptr);
    logic [IDW:0]   res;
    logic [IDW-1:0] idx;
    res = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = IDW'((int'(ptr) + i) % NREQ);
      if (valid[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  assign w_pick  = rr_pick(iReqValid, r_rr_ptr);
  assign w_gid   = w_pick[IDW-1:0];
  assign w_grant = iRstN && !iFlush && (r_state == ST_IDLE) && w_pick[IDW];

  always_comb begin
    oReqReady = '0;
    if (w_grant) oReqReady[w_gid] = 1'b1;
  end

  adder_reg #(.BITWIDTH(BITWIDTH)) u_adder (
    .i_clk   (iClk),
    .i_rst_n (iRstN),
    .i_en    (w_grant),
    .i_clr   (iFlush),
    .i_a     (iReqData0[w_gid]),
    .i_b     (iReqData1[w_gid]),
    .o_sum   (w_sum)
  );

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      r_state  <= ST_IDLE;
      r_rr_ptr <= '0;
      r_rsp_id <= '0;
    end else if (iFlush) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_grant) begin
            r_state  <= ST_RESP;
            r_rsp_id <= w_gid;
            r_rr_ptr <= (w_gid == IDW'(NREQ - 1)) ? '0 : w_gid + 1'b1;
          end
        end
        ST_RESP: begin
          if (iRspReady) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign oRspValid = (r_state == ST_RESP);
  assign oRspId    = r_rsp_id;
  assign oRspData  = w_sum;
  assign oBusy     = (r_state != ST_IDLE);
  assign oDbgState = r_state;

endmodule

// File: tb/tb_adder_arb.sv
// Bench for adder_arb: directed scenarios plus a random run against a queue-based reference model.
module tb_adder_arb;
  import adder_pkg::*;

  localparam int W   = 32;
  localparam int N   = 4;
  localparam int IDW = 2;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [N-1:0]         valid;
  logic [N-1:0]         rdy;
  logic [N-1:0][W-1:0]  d0;
  logic [N-1:0][W-1:0]  d1;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [IDW-1:0]       rsp_id;
  logic [W:0]           rsp_data;
  logic                 flush;
  logic                 busy;
  state_e               dbg_state;

  always #5 clk = ~clk;

  adder_arb #(.BITWIDTH(W), .NREQ(N)) dut (
    .iClk      (clk),
    .iRstN     (rst_n),
    .iReqValid (valid),
    .oReqReady (rdy),
    .iReqData0 (d0),
    .iReqData1 (d1),
    .oRspValid (rsp_valid),
    .iRspReady (rsp_ready),
    .oRspId    (rsp_id),
    .oRspData  (rsp_data),
    .iFlush    (flush),
    .oBusy     (busy),
    .oDbgState (dbg_state)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: a pending result lives in exp_q as {id, sum}; empty queue means idle.
  logic [W+IDW:0] exp_q[$];
  int             m_ptr = 0;
  int             grant_log[$];
  int             n_rsp_model = 0;
  int             n_rsp_dut = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int i = 0; i < N; i++) begin
      if (v[(p + i) % N]) return (p + i) % N;
    end
    return -1;
  endfunction

  // Called at a negedge after inputs are driven: checks outputs, then advances the model on the edge.
  task automatic step();
    logic [N-1:0] exp_ready;
    logic         exp_rsp;
    logic [W:0]   s;
    int           g;
    #1;
    exp_ready = '0;
    g = pick(valid, m_ptr);
    if (rst_n && !flush && exp_q.size() == 0 && g >= 0) exp_ready[g] = 1'b1;
    exp_rsp = rst_n && (exp_q.size() != 0);
    check("ready", 64'(rdy), 64'(exp_ready));
    check("rsp_valid", 64'(rsp_valid), 64'(exp_rsp));
    check("busy", 64'(busy), 64'(exp_rsp));
    check("dbg_state", 64'(dbg_state == ST_RESP), 64'(exp_rsp));
    check("excl", 64'((|rdy) & rsp_valid), 64'(0));
    if (!rst_n) begin
      check("rst_id", 64'(rsp_id), 64'(0));
      check("rst_data", 64'(rsp_data), 64'(0));
    end else if (exp_q.size() != 0) begin
      check("rsp_id", 64'(rsp_id), 64'(exp_q[0][W+IDW:W+1]));
      check("rsp_data", 64'(rsp_data), 64'(exp_q[0][W:0]));
    end
    if (rst_n && rsp_valid && rsp_ready && !flush) n_rsp_dut++;
    @(posedge clk);
    if (!rst_n) begin
      exp_q.delete();
      m_ptr = 0;
    end else if (flush) begin
      if (exp_q.size() != 0) void'(exp_q.pop_front());
    end else if (exp_q.size() == 0) begin
      if (g >= 0) begin
        s = W'(d0[g]) + W'(d1[g]);
        s = {1'b0, d0[g]} + {1'b0, d1[g]};
        exp_q.push_back({IDW'(g), s});
        m_ptr = (g + 1) % N;
        grant_log.push_back(g);
      end
    end else if (rsp_ready) begin
      void'(exp_q.pop_front());
      n_rsp_model++;
    end
    @(negedge clk);
  endtask

  int exp_order[5] = '{0, 1, 2, 3, 0};
  int cyc;

  initial begin
    rst_n = 1'b0; valid = '1; rsp_ready = 1'b1; flush = 1'b0;
    for (int i = 0; i < N; i++) begin d0[i] = $urandom; d1[i] = $urandom; end
    @(negedge clk);
    step(); step();
    rst_n = 1'b1;

    // Round-robin with every requester valid: grants 0,1,2,3,0.
    for (int c = 0; c < 10; c++) begin
      for (int i = 0; i < N; i++) begin d0[i] = $urandom; d1[i] = $urandom; end
      step();
    end
    check("rr_count", 64'(grant_log.size()), 64'(5));
    for (int i = 0; i < 5 && i < grant_log.size(); i++)
      check("rr_order", 64'(grant_log[i]), 64'(exp_order[i]));

    // Single requester 1: 5 + 7.
    valid = 4'b0010; d0[1] = 32'd5; d1[1] = 32'd7;
    #1 check("single_ready", 64'(rdy), 64'(4'b0010));
    step();
    valid = '0;
    #1 check("single_id", 64'(rsp_id), 64'(1));
    check("single_data", 64'(rsp_data), 64'(12));
    step();

    // Backpressure: hold the result five cycles while all requesters wait.
    valid = 4'b0001; d0[0] = $urandom; d1[0] = $urandom;
    step();
    valid = '1; rsp_ready = 1'b0;
    for (int c = 0; c < 5; c++) step();
    rsp_ready = 1'b1; valid = '0;
    step();
    #1 check("bp_idle", 64'(busy), 64'(0));

    // Carry out of the top bit.
    valid = 4'b1000; d0[3] = 32'hFFFF_FFFF; d1[3] = 32'h0000_0001;
    step();
    valid = '0;
    #1 check("carry_data", 64'(rsp_data), 64'h1_0000_0000);
    step();

    // Flush in RESP with the consumer ready: result dropped, pointer kept.
    valid = 4'b0100;
    step();
    valid = '0; flush = 1'b1;
    step();
    flush = 1'b0;
    #1 check("flush_rsp", 64'(rsp_valid), 64'(0));
    check("flush_busy", 64'(busy), 64'(0));
    valid = '1;
    #1 check("flush_next", 64'(rdy), 64'(4'b1000));
    step();
    valid = '0;
    step();

    // Asynchronous reset while a result is pending.
    valid = 4'b0001;
    step();
    rst_n = 1'b0; valid = 4'b1100;
    step(); step();
    rst_n = 1'b1;
    #1 check("post_rst_ready", 64'(rdy), 64'(4'b0100));
    check("post_rst_rsp", 64'(rsp_valid), 64'(0));
    step();
    valid = '0;
    step();

    // Random run of 1000 accepted results.
    n_rsp_model = 0; n_rsp_dut = 0; cyc = 0;
    while (n_rsp_model < 1000 && cyc < 20000) begin
      valid = N'($urandom_range(0, 15));
      for (int i = 0; i < N; i++) begin
        d0[i] = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
        d1[i] = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 59) == 0);
      step();
      cyc++;
    end
    flush = 1'b0;
    check("rand_done", 64'(n_rsp_model >= 1000), 64'(1));
    check("rand_rsp_count", 64'(n_rsp_dut), 64'(n_rsp_model));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
